// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin grant on contention
// and a clear sequence that zeroes registers 1..NUM_REGS-1, one per cycle.
module reg_write_arbiter #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        clear_start,
  output logic        busy,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        grant_id
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_t      state;
  logic [4:0]  counter;
  logic        lastGrant;
  logic        xfer0, xfer1, anyXfer;
  logic [4:0]  winReg;
  logic [31:0] winData;

  // Clear and reset both block acceptance; on contention the requester that
  // did not win last time gets the slot.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == ARB && !clear_start) begin
      if (req0_valid && req1_valid) begin
        req0_ready = lastGrant;
        req1_ready = !lastGrant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer0   = req0_valid && req0_ready;
  assign xfer1   = req1_valid && req1_ready;
  assign anyXfer = xfer0 || xfer1;
  assign winReg  = xfer1 ? req1_reg  : req0_reg;
  assign winData = xfer1 ? req1_data : req0_data;
  assign busy    = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      counter   <= 5'd0;
      lastGrant <= 1'b1;
      RegWrite  <= 1'b0;
      WriteReg  <= 5'd0;
      WriteData <= 32'd0;
      grant_id  <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          RegWrite <= 1'b0;
          if (clear_start) begin
            state   <= CLEAR;
            counter <= 5'd1;
          end else if (anyXfer) begin
            lastGrant <= xfer1;
            // Writes to r0 are consumed but never reach the register file.
            if (winReg != 5'd0) begin
              RegWrite  <= 1'b1;
              WriteReg  <= winReg;
              WriteData <= winData;
              grant_id  <= xfer1;
            end
          end
        end
        CLEAR: begin
          RegWrite  <= 1'b1;
          WriteReg  <= counter;
          WriteData <= 32'd0;
          grant_id  <= 1'b0;
          if (counter == LAST_REG) begin
            state   <= ARB;
            counter <= 5'd0;
          end else begin
            counter <= counter + 5'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: arbitration order, r0 drop, clear sweep,
// clear re-pulse and reset abort.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clear_start, busy;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        grant_id;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .busy(busy),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'hAA;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'hBB;
    clear_start = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);

    // Single requester 0.
    reset = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("single_rw", RegWrite, 1);
    chk("single_reg", WriteReg, 3);
    chk("single_data", WriteData, 32'hAA);
    chk("single_gid", grant_id, 0);
    tick();
    chk("idle_rw", RegWrite, 0);
    chk("idle_reg_hold", WriteReg, 3);
    chk("idle_data_hold", WriteData, 32'hAA);

    // Contention from reset: grants alternate starting with req0; same target register.
    doReset();
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h50;
    req1_valid = 1'b1; req1_reg = 5'd5; req1_data = 32'h51;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_rw", RegWrite, 1);
      chk("rr_gid", grant_id, i % 2);
      chk("rr_data", WriteData, (i % 2 == 0) ? 32'h50 : 32'h51);
    end
    chk("rr_last_wins", WriteData, 32'h51);

    // Write to r0 is accepted but suppressed.
    req0_valid = 1'b0;
    req1_reg = 5'd0; req1_data = 32'h1234;
    #1;
    chk("r0_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("r0_rw", RegWrite, 0);

    // Full clear with req0 pending and a clear_start re-pulse mid-sweep.
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h77;
    clear_start = 1'b1;
    #1;
    chk("clr_start_ready0", req0_ready, 0);
    tick();
    clear_start = 1'b0;
    chk("clr_busy_first", busy, 1);
    chk("clr_rw_first", RegWrite, 0);
    chk("clr_ready0_busy", req0_ready, 0);
    for (int i = 1; i <= 31; i++) begin
      clear_start = (i == 5);
      tick();
      chk("clr_rw", RegWrite, 1);
      chk("clr_reg", WriteReg, i);
      chk("clr_data", WriteData, 0);
      chk("clr_gid", grant_id, 0);
      chk("clr_busy", busy, (i < 31) ? 1 : 0);
    end
    clear_start = 1'b0;
    chk("clr_end_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("post_clr_rw", RegWrite, 1);
    chk("post_clr_reg", WriteReg, 7);
    chk("post_clr_data", WriteData, 32'h77);
    tick();
    chk("post_clr_idle", RegWrite, 0);
    chk("post_clr_busy", busy, 0);

    // Reset during the 10th clear write aborts the sweep.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk("abort_reg10", WriteReg, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rw", RegWrite, 0);
    chk("abort_busy", busy, 0);
    req0_valid = 1'b1; req0_reg = 5'd2; req0_data = 32'h22;
    #1;
    chk("abort_arb_ready0", req0_ready, 1);
    req0_valid = 1'b0;
    tick();
    chk("abort_no_reg11", WriteReg, 0);
    chk("abort_rw_after", RegWrite, 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
